column_packer: RTL and testbench
================================

Name: column_packer

Overview:
- Writer-side feeder for the convolution kernel's column FIFO.
- Accepts a raster-order stream of bfloat16 pixels and buffers the two previous image rows in line buffers.
- Once three rows are available, emits one 48-bit vertical column (3 pixels) per accepted pixel into the syn_fifo write port.
- The kernel reads these columns to build its 3x3 window.

Parameters:
- DATA_W, 16, pixel width (bfloat16).
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (>=3).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- pix_in  input  DATA_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in valid.
- pix_ready  output  1  block can accept pix_in this cycle.
- fifo_full  input  1  downstream syn_fifo full.
- col_out  output  3*DATA_W  column to FIFO: [15:0] oldest row (r-2), [31:16] row r-1, [47:32] newest row r.
- write_en  output  1  FIFO write strobe; col_out valid when high.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset low, asynchronous):
  - col_cnt=0, row_cnt=0, col_valid=0, col_out=0, write_en=0, frame_done=0.
  - pix_ready=1 once reset is released.
  - Line-buffer contents are don't-care; row_cnt gating ensures they are never emitted before being written.
- Output register: single-entry col register with col_valid flag.
- pix_ready = !col_valid || !fifo_full (combinational).
- write_en = col_valid && !fifo_full (combinational). A write occurs in every cycle write_en is high.
- Accept = pix_valid && pix_ready.
- On accept, with c = col_cnt:
  - lb1[c] <= lb0[c]; lb0[c] <= pix_in.
  - If row_cnt >= 2: col register <= {pix_in, lb0[c], lb1[c]} (pre-update values of lb0/lb1); col_valid <= 1.
  - If row_cnt < 2: no column is produced. col_valid <= 0 if the current column drained this cycle, otherwise it holds.
- No accept but write_en high: col_valid <= 0.
- Simultaneous drain and accept: the new column replaces the old one in the same cycle with no bubble, giving full throughput of one column per clk.
- Latency: a column appears on col_out/write_en exactly 1 clk after its newest pixel is accepted.
- Backpressure: while col_valid && fifo_full, col_out is held stable, write_en=0, pix_ready=0.
- Counters:
  - col_cnt wraps IMG_W-1 -> 0 and increments row_cnt.
  - row_cnt wraps IMG_H-1 -> 0 at end of frame.
  - frame_done pulses in the cycle after the final accept.
- Per frame: exactly (IMG_H-2)*IMG_W columns are emitted. Rows 0 and 1 of every frame, including frames after the first, emit nothing.
- Reset mid-operation: the in-flight column is discarded (write_en drops immediately) and counters return to frame start.

Optional Feature:
- COLPACK_ZERO_PAD_EN defined:
  - Rows 0 and 1 also emit columns. Any row slot above the image is forced to 16'h0000 (bfloat +0).
  - row 0 emits {pix,0,0}; row 1 emits {pix,lb0[c],0}.
  - Total IMG_H*IMG_W columns per frame.
- Not defined: behaviour exactly as above, no padding logic instantiated.

Test Plan (IMG_W=4, IMG_H=4, pixel value 16'h00RC for row R, col C):
- Stream a full frame with fifo_full=0:
  - exactly 8 write_en pulses.
  - first col_out = 48'h0020_0010_0000, last = 48'h0033_0023_0013.
  - frame_done pulses once, 1 clk after pixel 16'h0033.
- Hold fifo_full=1 for 3 cycles while col_valid:
  - col_out stays 48'h0021_0011_0001, pix_ready=0, no write.
  - After release, that column is written once and no pixel is lost.
- Back-to-back frames: the second frame's first write is 48'h0020_0010_0000, occurring only after 8 pixels of frame 2; no stale frame-1 data appears.
- Assert reset low mid-row 2 (after pixel 16'h0021):
  - write_en=0 asynchronously.
  - Restart the frame: the first column again appears only at row 2.
- pix_valid toggling 1/0 each cycle: columns are correct and in order, with write_en only on cycles following accepts.
- With COLPACK_ZERO_PAD_EN:
  - 16 writes.
  - first = 48'h0000_0000_0000 (pixel 0).
  - row1 col1 = 48'h0011_0001_0000.

Source files
------------

// File: rtl/column_packer.sv
// Raster-order pixel stream to 3-pixel vertical columns for the conv kernel's column FIFO.
// Optional build macro: COLPACK_ZERO_PAD_EN (rows 0/1 also emit, with zero rows above the image).
`timescale 1ns/1ps
module column_packer #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  fifo_full,
    output logic [3*DATA_W-1:0]   col_out,
    output logic                  write_en,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]          col_cnt_q, col_cnt_d;
    logic [RW-1:0]          row_cnt_q, row_cnt_d;
    logic [3*DATA_W-1:0]    col_q, col_d;
    logic                   col_valid_q, col_valid_d;
    logic                   frame_done_q, frame_done_d;

    logic [DATA_W-1:0]      lb0 [IMG_W];
    logic [DATA_W-1:0]      lb1 [IMG_W];
    logic [DATA_W-1:0]      lb0_rd, lb1_rd;
    logic [DATA_W-1:0]      mid_slot, old_slot;
    logic                   accept, emit;

    // Single-entry output stage: a drain and a refill may happen in the same cycle.
    assign pix_ready  = !col_valid_q || !fifo_full;
    assign write_en   = col_valid_q && !fifo_full;
    assign accept     = pix_valid && pix_ready;
    assign col_out    = col_q;
    assign frame_done = frame_done_q;

    assign lb0_rd = lb0[col_cnt_q];
    assign lb1_rd = lb1[col_cnt_q];

`ifdef COLPACK_ZERO_PAD_EN
    assign emit     = 1'b1;
    assign mid_slot = (row_cnt_q != '0)       ? lb0_rd : '0;
    assign old_slot = (row_cnt_q >= RW'(2))   ? lb1_rd : '0;
`else
    assign emit     = (row_cnt_q >= RW'(2));
    assign mid_slot = lb0_rd;
    assign old_slot = lb1_rd;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        col_d        = col_q;
        col_valid_d  = col_valid_q;
        frame_done_d = 1'b0;

        if (write_en) begin
            col_valid_d = 1'b0;
        end

        if (accept) begin
            if (emit) begin
                col_d       = {pix_in, mid_slot, old_slot};
                col_valid_d = 1'b1;
            end
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            col_q        <= '0;
            col_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            col_q        <= col_d;
            col_valid_q  <= col_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: line buffers are left unreset; row_cnt gating keeps unwritten entries from ever being emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_cnt_q] <= lb0_rd;
            lb0[col_cnt_q] <= pix_in;
        end
    end

`ifndef SYNTHESIS
    a_hold_under_backpressure : assert property (
        @(posedge clk) disable iff (!reset)
        (col_valid_q && fifo_full) |=> (col_valid_q && $stable(col_q))
    );
`endif

endmodule

// File: tb/tb_column_packer.sv
// Randomized self-checking bench for column_packer (IMG_W=4, IMG_H=4) against a frame-array reference model.
// Honours COLPACK_ZERO_PAD_EN when the design is built with it.
`timescale 1ns/1ps
module tb_column_packer;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

`ifdef COLPACK_ZERO_PAD_EN
    localparam int          EXP_WR        = W * H;
    localparam int          EXP_FIRST_ACC = 1;
    localparam logic [47:0] FIRST_COL     = 48'h0000_0000_0000;
`else
    localparam int          EXP_WR        = W * (H - 2);
    localparam int          EXP_FIRST_ACC = 2 * W + 1;
    localparam logic [47:0] FIRST_COL     = 48'h0020_0010_0000;
`endif
    localparam logic [47:0] LAST_COL = 48'h0033_0023_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              fifo_full;
    logic [3*DW-1:0]   col_out;
    logic              write_en;
    logic              frame_done;

    always #5 clk = ~clk;

    column_packer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .fifo_full  (fifo_full),
        .col_out    (col_out),
        .write_en   (write_en),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [47:0] col;
        int          frame;
        int          acc_idx;
    } col_t;

    // Reference model state: the current frame as a 2-D picture plus columns awaiting a FIFO write.
    col_t         pend[$];
    logic [15:0]  img [H][W];
    int           mr, mc, n_acc, frame_id;
    logic         exp_fd;
    int           wr_cnt    [8];
    int           first_acc [8];
    logic [47:0]  cols      [8][16];
    int           fd_seen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] model_col(input int r, input int c, input logic [15:0] p);
        logic [15:0] mid, old;
        mid = (r >= 1) ? img[r-1][c] : 16'h0000;
        old = (r >= 2) ? img[r-2][c] : 16'h0000;
        return {p, mid, old};
    endfunction

    function automatic bit model_emits(input int r);
`ifdef COLPACK_ZERO_PAD_EN
        return 1'b1;
`else
        return r >= 2;
`endif
    endfunction

    task automatic model_reset();
        pend.delete();
        mr = 0; mc = 0; n_acc = 0;
        exp_fd = 1'b0;
    endtask

    // One clock: drive, sample mid-cycle against the model, then advance the model past the edge.
    task automatic cycle(input logic v, input logic [15:0] p, input logic ff, output logic acc);
        logic exp_we, exp_rdy;
        col_t e;
        pix_valid = v; pix_in = p; fifo_full = ff;
        @(negedge clk);
        exp_we  = (pend.size() != 0) && !ff;
        exp_rdy = (pend.size() == 0) || !ff;
        check("write_en", write_en, exp_we);
        check("pix_ready", pix_ready, exp_rdy);
        check("frame_done", frame_done, exp_fd);
        if (pend.size() != 0) check("col_out", col_out, pend[0].col);
        if (frame_done) fd_seen++;
        acc = v && exp_rdy;
        @(posedge clk); #1;
        exp_fd = 1'b0;
        if (exp_we) begin
            e = pend.pop_front();
            if (wr_cnt[e.frame] == 0) first_acc[e.frame] = e.acc_idx;
            if (wr_cnt[e.frame] < 16) cols[e.frame][wr_cnt[e.frame]] = e.col;
            wr_cnt[e.frame]++;
        end
        if (acc) begin
            n_acc++;
            if (model_emits(mr)) begin
                e.col = model_col(mr, mc, p); e.frame = frame_id; e.acc_idx = n_acc;
                pend.push_back(e);
            end
            img[mr][mc] = p;
            if (mc == W - 1) begin
                mc = 0;
                if (mr == H - 1) begin
                    mr = 0; exp_fd = 1'b1; frame_id++; n_acc = 0;
                end else begin
                    mr++;
                end
            end else begin
                mc++;
            end
        end
    endtask

    task automatic send(input logic [15:0] p);
        logic acc;
        int   t;
        t = 0; acc = 1'b0;
        while (!acc && t < 50) begin
            cycle(1'b1, p, 1'b0, acc);
            t++;
        end
        check("send_bound", acc, 1'b1);
    endtask

    // mode 0: 16'h00RC pixels, continuous; 1: random pixels, valid toggling; 2: random valid/full.
    task automatic stream_frame(input int mode, input bit bp, input int stop_after);
        logic [15:0] p;
        logic        acc;
        int          t;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (stop_after >= 0 && r * W + c == stop_after) return;
                p = (mode == 0) ? {8'h00, 4'(r), 4'(c)} : 16'($urandom);
                if (bp && r == 2 && c == 2) begin
                    repeat (3) begin
                        cycle(1'b1, p, 1'b1, acc);
                        check("bp_acc", acc, 1'b0);
                        check("bp_col", col_out, 48'h0021_0011_0001);
                        check("bp_ready", pix_ready, 1'b0);
                        check("bp_we", write_en, 1'b0);
                    end
                end
                if (mode == 2) begin
                    t = 0; acc = 1'b0;
                    while (!acc && t < 200) begin
                        cycle(1'($urandom_range(0, 1)), p, ($urandom_range(0, 2) == 0), acc);
                        t++;
                    end
                    check("rand_send_bound", acc, 1'b1);
                end else begin
                    send(p);
                end
                if (mode == 1) cycle(1'b0, 16'($urandom), 1'b0, acc);
            end
        end
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < 8; i++) begin
            wr_cnt[i] = 0; first_acc[i] = 0;
        end
        frame_id = 0; fd_seen = 0;
        model_reset();
        reset = 1'b0; pix_valid = 1'b0; pix_in = '0; fifo_full = 1'b0;
        #3;
        check("rst_write_en", write_en, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_col_out", col_out, 48'h0);
        check("rst_pix_ready", pix_ready, 1'b1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        stream_frame(0, 1'b0, -1);      // frame 0
        stream_frame(0, 1'b1, -1);      // frame 1, back-to-back, with backpressure
        repeat (3) cycle(1'b0, 16'h0, 1'b0, acc);
        stream_frame(1, 1'b0, -1);      // frame 2
        stream_frame(2, 1'b0, -1);      // frame 3
        repeat (4) cycle(1'b0, 16'h0, 1'b0, acc);

        // Frame 4 is cut by reset right after pixel 16'h0021 while a column is in flight.
        stream_frame(0, 1'b0, 2 * W + 2);
        check("pre_rst_we", write_en, pend.size() != 0);
        pix_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_we", write_en, 1'b0);
        check("mid_rst_col", col_out, 48'h0);
        check("mid_rst_ready", pix_ready, 1'b1);
        model_reset();
        frame_id++;
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        stream_frame(0, 1'b0, -1);      // frame 5
        repeat (3) cycle(1'b0, 16'h0, 1'b0, acc);

        check("f0_writes", wr_cnt[0], EXP_WR);
        check("f0_first", cols[0][0], FIRST_COL);
        check("f0_last", cols[0][EXP_WR-1], LAST_COL);
        check("f0_first_acc", first_acc[0], EXP_FIRST_ACC);
`ifdef COLPACK_ZERO_PAD_EN
        check("f0_r1c1", cols[0][W+1], 48'h0011_0001_0000);
`endif
        check("f1_writes", wr_cnt[1], EXP_WR);
        check("f1_first", cols[1][0], FIRST_COL);
        check("f1_last", cols[1][EXP_WR-1], LAST_COL);
        check("f1_first_acc", first_acc[1], EXP_FIRST_ACC);
        check("f2_writes", wr_cnt[2], EXP_WR);
        check("f3_writes", wr_cnt[3], EXP_WR);
        check("f5_writes", wr_cnt[5], EXP_WR);
        check("f5_first", cols[5][0], FIRST_COL);
        check("f5_first_acc", first_acc[5], EXP_FIRST_ACC);
        check("frame_done_pulses", fd_seen, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
